bcd_digit_streamer: RTL and testbench
=====================================

BCD_DIGIT_STREAMER -- requirements
Module: bcd_digit_streamer

Interface
REQ-001 Parameter ASCII_BASE, default 8'h30, is the character code added to each valid BCD digit.
REQ-002 Parameter BAD_CHAR, default 8'h3F ('?'), is the character emitted for a nibble greater than 9.
REQ-003 Port clk, input, 1 bit, is the single clock; all state SHALL change only on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the synchronous active-low reset.
REQ-005 Port start, input, 1 bit, is a request to stream a new value.
REQ-006 Port bcd_in, input, 12 bits, is the 3-digit packed BCD value: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-007 Port busy, output, 1 bit, is high while a value is being streamed.
REQ-008 Port char_valid, output, 1 bit, is high when char_data holds a character for the LCD writer.
REQ-009 Port char_data, output, 8 bits, is the ASCII character offered.
REQ-010 Port char_ready, input, 1 bit, is high when the LCD writer accepts char_data.
REQ-011 Port done, output, 1 bit, is a one-cycle pulse after the last character is accepted.

Function
REQ-012 The block SHALL implement the states IDLE, SEND_H, SEND_T and SEND_U.
REQ-013 In IDLE with start=1, the block SHALL capture bcd_in into an internal 12-bit register and enter SEND_H on the next edge.
REQ-014 The block SHALL ignore start in any state other than IDLE, and later changes on bcd_in SHALL NOT affect the captured value.
REQ-015 busy SHALL be 0 in IDLE and 1 in SEND_H, SEND_T and SEND_U.
REQ-016 char_valid SHALL be 1 in every SEND_* state and 0 in IDLE, so it rises exactly one cycle after start is accepted.
REQ-017 char_data SHALL be the hundreds character in SEND_H, the tens character in SEND_T and the units character in SEND_U, and SHALL hold stable while char_valid=1 and char_ready=0.
REQ-018 A transfer SHALL occur in a cycle with char_valid=1 and char_ready=1, and the state SHALL advance SEND_H->SEND_T->SEND_U->IDLE only on a transfer.
REQ-019 A digit d from 0 to 9 SHALL map to ASCII_BASE+d, and d from 10 to 15 SHALL map to BAD_CHAR.
REQ-020 done SHALL be 1 for exactly the one cycle following the SEND_U transfer (the first cycle back in IDLE), and 0 otherwise.
REQ-021 A start asserted in the cycle where done=1 SHALL be accepted, giving a minimum of 4 cycles per value when char_ready is held at 1.
REQ-022 char_ready asserted while char_valid=0 SHALL have no effect.

Reset
REQ-023 With rst_n=0 at a clock edge, the block SHALL enter IDLE and set busy=0, char_valid=0, char_data=8'h00, done=0 and the captured register to 12'h000.
REQ-024 A reset asserted mid-stream SHALL abort the stream with no done pulse, and any start asserted during reset SHALL be ignored.

Configuration
REQ-025 With macro LEADING_BLANK_EN defined, a hundreds digit of 0 SHALL be emitted as 8'h20, and a tens digit of 0 SHALL be emitted as 8'h20 when the hundreds digit is also 0.
REQ-026 With LEADING_BLANK_EN defined, the units digit SHALL never be blanked, and the character count SHALL remain 3.
REQ-027 Without LEADING_BLANK_EN, every zero digit SHALL be emitted as ASCII_BASE.

Verification
REQ-028 Accept and hold: bcd_in=12'h472, start pulse, char_ready=1 -> '4','7','2' (8'h34,8'h37,8'h32) on consecutive cycles, then done=1 for one cycle.
REQ-029 Backpressure: bcd_in=12'h105, char_ready=0 for 5 cycles after char_valid rises -> char_data held at 8'h31; with char_ready then at 1 -> 8'h30, 8'h35, then done.
REQ-030 Leading zeros: bcd_in=12'h007 -> 8'h30,8'h30,8'h37 without the macro, and 8'h20,8'h20,8'h37 with LEADING_BLANK_EN; bcd_in=12'h000 with the macro -> 8'h20,8'h20,8'h30.
REQ-031 Invalid digit: bcd_in=12'h9A3 -> 8'h39, 8'h3F, 8'h33.
REQ-032 Back-to-back and ignored start: start pulsed again in SEND_T -> no effect; start in the done cycle with 12'h999 -> second stream 8'h39 x3 begins the next cycle.
REQ-033 Reset mid-stream: rst_n=0 during SEND_T -> next cycle busy=0, char_valid=0, char_data=8'h00, and done never pulses.

Source files
------------

// File: rtl/bcd_digit_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_streamer
//  Purpose  : Streams a captured 3-digit packed BCD value to an LCD writer
//             as three ASCII characters (hundreds, tens, units) over a
//             valid/ready handshake, then pulses done for one cycle.
//  Options  : LEADING_BLANK_EN - when defined, leading zero digits in the
//             hundreds/tens positions are sent as spaces (8'h20).
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_streamer #(
  parameter logic [7:0] ASCII_BASE = 8'h30,
  parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] bcd_in,
  output logic        busy,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_H = 2'd1,
    SEND_T = 2'd2,
    SEND_U = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic        done_q, done_d;

  logic [7:0]  hund_char;
  logic [7:0]  tens_char;
  logic [7:0]  unit_char;

  // Nibbles above 9 are not decimal digits and get a visible marker instead.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_BASE + {4'h0, d}) : BAD_CHAR;
  endfunction

  // Per-position characters derived from the captured value only, so
  // char_data cannot move while a character is waiting for char_ready.
`ifdef LEADING_BLANK_EN
  always_comb begin
    hund_char = digit_char(bcd_q[11:8]);
    tens_char = digit_char(bcd_q[7:4]);
    unit_char = digit_char(bcd_q[3:0]);
    if (bcd_q[11:8] == 4'd0) begin
      hund_char = 8'h20;
      if (bcd_q[7:4] == 4'd0) begin
        tens_char = 8'h20;
      end
    end
  end
`else
  always_comb begin
    hund_char = digit_char(bcd_q[11:8]);
    tens_char = digit_char(bcd_q[7:4]);
    unit_char = digit_char(bcd_q[3:0]);
  end
`endif

  // Next-state logic: capture on start in IDLE, advance one digit per transfer.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          state_d = SEND_H;
        end
      end
      SEND_H: begin
        if (char_ready) state_d = SEND_T;
      end
      SEND_T: begin
        if (char_ready) state_d = SEND_U;
      end
      SEND_U: begin
        if (char_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured value and done pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= 12'h000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // Output decode: handshake flags and the character for the current digit.
  always_comb begin
    busy       = (state_q != IDLE);
    char_valid = (state_q != IDLE);
    done       = done_q;
    char_data  = 8'h00;
    case (state_q)
      SEND_H:  char_data = hund_char;
      SEND_T:  char_data = tens_char;
      SEND_U:  char_data = unit_char;
      default: char_data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_digit_streamer
//  Purpose  : Self-checking bench for bcd_digit_streamer: a per-cycle
//             behavioural model plus directed streams with literal results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic        char_ready = 1'b0;
  logic        busy;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        done;

  int errors = 0;
  int checks = 0;

  bcd_digit_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bcd_in     (bcd_in),
    .busy       (busy),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Character for digit position pos (0=hundreds, 1=tens, 2=units) of v.
  function automatic logic [7:0] exp_char(input logic [11:0] v, input int pos);
    int d, h;
    d = (v >> (4 * (2 - pos))) & 15;
    h = (v >> 8) & 15;
`ifdef LEADING_BLANK_EN
    if (pos == 0 && d == 0) return 8'h20;
    if (pos == 1 && d == 0 && h == 0) return 8'h20;
`endif
    if (d <= 9) return 8'(48 + d);
    return 8'h3F;
  endfunction

  int         m_idx = -1;   // -1 idle, else index of character on offer
  logic [7:0] m_chars [3];
  bit         m_done = 1'b0;
  bit         m_init = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idx  <= -1;
      m_done <= 1'b0;
      m_init <= 1'b1;
    end else if (m_idx < 0) begin
      m_done <= 1'b0;
      if (start) begin
        for (int i = 0; i < 3; i++) m_chars[i] <= exp_char(bcd_in, i);
        m_idx <= 0;
      end
    end else begin
      m_done <= 1'b0;
      if (char_ready) begin
        if (m_idx == 2) begin
          m_idx  <= -1;
          m_done <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, midway between edges.
  always @(negedge clk) begin
    if (m_init) begin
      chk("model_busy", 32'(busy), 32'(m_idx >= 0));
      chk("model_valid", 32'(char_valid), 32'(m_idx >= 0));
      chk("model_done", 32'(done), 32'(m_done));
      if (m_idx >= 0) chk("model_data", 32'(char_data), 32'(m_chars[m_idx]));
    end
  end

  // Record accepted characters and done pulses for the literal checks.
  logic [7:0] cap_q[$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (char_valid && char_ready) cap_q.push_back(char_data);
    if (done) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    #1;
  endtask

  task automatic chk_cap(input string name, input int off,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    chk({name, "_len"}, 32'(cap_q.size() >= off + 3), 32'd1);
    if (cap_q.size() >= off + 3) begin
      chk({name, "_c0"}, 32'(cap_q[off]),     32'(e0));
      chk({name, "_c1"}, 32'(cap_q[off + 1]), 32'(e1));
      chk({name, "_c2"}, 32'(cap_q[off + 2]), 32'(e2));
    end
  endtask

  task automatic run3(input string name, input logic [11:0] v,
                      input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    int dc;
    tick();
    cap_q.delete();
    dc         = done_cnt;
    bcd_in     = v;
    start      = 1'b1;
    char_ready = 1'b1;
    tick();
    start = 1'b0;
    wait_done(name, 20);
    chk_cap(name, 0, e0, e1, e2);
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'(dc + 1));
  endtask

  initial begin
    int dc;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    // Reset with start and char_ready high: nothing may happen.
    rst_n = 1'b0;
    start = 1'b1;
    char_ready = 1'b1;
    bcd_in = 12'h555;
    repeat (3) tick();
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_data",  32'(char_data),  32'h00);
    chk("rst_done",  32'(done),       32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_ready_busy", 32'(busy), 32'd0);

    // Basic stream.
    run3("s472", 12'h472, 8'h34, 8'h37, 8'h32);
    tick();
    chk("s472_done_one_cycle", 32'(done), 32'd0);

    // Backpressure on the hundreds character.
    tick();
    cap_q.delete();
    dc = done_cnt;
    char_ready = 1'b0;
    bcd_in = 12'h105;
    start = 1'b1;
    tick();
    start = 1'b0;
    bcd_in = 12'h888;
    chk("bp_valid_rise", 32'(char_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'(char_data), 32'h31);
    end
    @(posedge clk);
    #1;
    char_ready = 1'b1;
    wait_done("bp", 20);
    chk_cap("bp", 0, 8'h31, 8'h30, 8'h35);
    chk("bp_done_cnt", 32'(done_cnt), 32'(dc + 1));

    // Leading zeros and invalid digits.
`ifdef LEADING_BLANK_EN
    run3("s007", 12'h007, 8'h20, 8'h20, 8'h37);
    run3("s000", 12'h000, 8'h20, 8'h20, 8'h30);
    run3("s050", 12'h050, 8'h20, 8'h35, 8'h30);
`else
    run3("s007", 12'h007, 8'h30, 8'h30, 8'h37);
    run3("s000", 12'h000, 8'h30, 8'h30, 8'h30);
    run3("s050", 12'h050, 8'h30, 8'h35, 8'h30);
`endif
    run3("s9A3", 12'h9A3, 8'h39, 8'h3F, 8'h33);
    run3("sFB6", 12'hFB6, 8'h3F, 8'h3F, 8'h36);

    // Ignored start in SEND_T, then start in the done cycle.
    tick();
    cap_q.delete();
    dc = done_cnt;
    bcd_in = 12'h456;
    start = 1'b1;
    char_ready = 1'b1;
    tick();              // SEND_H
    start = 1'b0;
    tick();              // SEND_T
    start = 1'b1;
    bcd_in = 12'h111;
    tick();              // SEND_U
    start = 1'b0;
    bcd_in = 12'h999;
    tick();              // IDLE, done cycle
    chk("b2b_done_cycle", 32'(done), 32'd1);
    start = 1'b1;
    tick();              // second stream accepted
    start = 1'b0;
    chk("b2b_restart_valid", 32'(char_valid), 32'd1);
    chk("b2b_restart_data", 32'(char_data), 32'h39);
    wait_done("b2b", 20);
    chk("b2b_len", 32'(cap_q.size()), 32'd6);
    chk_cap("b2b_first", 0, 8'h34, 8'h35, 8'h36);
    chk_cap("b2b_second", 3, 8'h39, 8'h39, 8'h39);
    chk("b2b_done_cnt", 32'(done_cnt), 32'(dc + 2));

    // Reset during SEND_T aborts without done.
    tick();
    bcd_in = 12'h321;
    start = 1'b1;
    char_ready = 1'b1;
    tick();              // SEND_H
    start = 1'b0;
    tick();              // SEND_T
    chk("mid_in_send_t", 32'(char_data), 32'h32);
    dc = done_cnt;
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_valid", 32'(char_valid), 32'd0);
    chk("mid_rst_data",  32'(char_data),  32'h00);
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    repeat (6) tick();
    chk("mid_no_done", 32'(done_cnt), 32'(dc));
    chk("mid_idle_busy", 32'(busy), 32'd0);

    // Normal operation after the abort.
    run3("s268", 12'h268, 8'h32, 8'h36, 8'h38);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
